// File: rtl/mem_arb_pkg.sv
// Shared constants for mem_arbiter: FSM state codes, one-hot grant values and
// the read data returned on a watchdog abort.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [1:0] GRANT_NONE   = 2'b00;
    localparam logic [1:0] GRANT_CORE   = 2'b01;
    localparam logic [1:0] GRANT_LOADER = 2'b10;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// BUSY-phase watchdog for mem_arbiter; only instantiated when MEM_ARB_TIMEOUT_EN is defined.
// Counts BUSY cycles without mem_ready and flags expiry on the (TimeoutCycles)th such cycle.
module mem_arb_watchdog #(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic busy_i,
    input  logic ready_i,
    output logic expire_o
);

    localparam int unsigned CntWidth = $clog2(TimeoutCycles);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

    logic [CntWidth-1:0] r_cnt;

    // Held at zero outside BUSY so every BUSY entry starts a fresh count.
    always_ff @(posedge clk_i) begin
        if (reset_i || !busy_i) begin
            r_cnt <= '0;
        end else if (!ready_i) begin
            r_cnt <= r_cnt + CntWidth'(1);
        end
    end

    assign expire_o = busy_i & ~ready_i & (r_cnt == CntLast);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single picorv32-style native memory port,
// with loader lock bursts. Define MEM_ARB_TIMEOUT_EN to enable the BUSY watchdog and err_o.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 req0_valid_i,
    input  logic [AddrWidth-1:0] req0_addr_i,
    input  logic [DataWidth-1:0] req0_wdata_i,
    input  logic [3:0]           req0_wstrb_i,
    output logic                 req0_ready_o,
    output logic [DataWidth-1:0] req0_rdata_o,
    input  logic                 req1_valid_i,
    input  logic [AddrWidth-1:0] req1_addr_i,
    input  logic [DataWidth-1:0] req1_wdata_i,
    input  logic [3:0]           req1_wstrb_i,
    output logic                 req1_ready_o,
    output logic [DataWidth-1:0] req1_rdata_o,
    input  logic                 req1_lock_i,
    output logic                 mem_valid_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [3:0]           mem_wstrb_o,
    input  logic [DataWidth-1:0] mem_rdata_i,
    input  logic                 mem_ready_i,
    output logic [1:0]           grant_o,
    output logic                 err_o
);

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [1:0] r_grant;
    logic [1:0] w_grant_next;
    logic       r_rr_ptr;
    logic       w_rr_ptr_next;
    logic       r_lock;
    logic       w_lock_next;

    logic                 w_busy;
    logic                 w_sel1;
    logic                 w_req_valid;
    logic                 w_drop;
    logic                 w_done;
    logic                 w_timeout;
    logic                 w_finish;
    logic [DataWidth-1:0] w_rdata;

    assign w_busy      = (r_state == ST_BUSY);
    assign w_sel1      = r_grant[1];
    assign w_req_valid = w_sel1 ? req1_valid_i : req0_valid_i;
    assign w_drop      = w_busy & ~w_req_valid;
    assign w_done      = w_busy & w_req_valid & mem_ready_i;
    // A pending reset suppresses the completion pulse of the cycle it lands in.
    assign w_finish    = (w_done | w_timeout) & ~reset_i;
    assign w_rdata     = w_done ? mem_rdata_i : DataWidth'(TIMEOUT_RDATA);

`ifdef MEM_ARB_TIMEOUT_EN
    logic w_expire;
    logic r_err;

    mem_arb_watchdog #(
        .TimeoutCycles(TimeoutCycles)
    ) u_watchdog (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .busy_i  (w_busy),
        .ready_i (mem_ready_i),
        .expire_o(w_expire)
    );

    assign w_timeout = w_expire & w_req_valid;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (TimeoutCycles < 2);
    assign w_timeout    = 1'b0;
    assign err_o        = 1'b0;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_grant_next  = r_grant;
        w_rr_ptr_next = r_rr_ptr;
        w_lock_next   = r_lock;
        case (r_state)
            ST_IDLE: begin
                if (req0_valid_i || req1_valid_i) begin
                    w_state_next = ST_BUSY;
                    if (req0_valid_i && req1_valid_i) begin
                        w_grant_next = r_rr_ptr ? GRANT_LOADER : GRANT_CORE;
                    end else begin
                        w_grant_next = req1_valid_i ? GRANT_LOADER : GRANT_CORE;
                    end
                end
            end
            ST_BUSY: begin
                if (w_drop) begin
                    w_state_next = ST_IDLE;
                    w_grant_next = GRANT_NONE;
                end else if (w_done) begin
                    w_state_next = ST_GAP;
                    w_grant_next = GRANT_NONE;
                    w_lock_next  = w_sel1 & req1_lock_i;
                    if (!(w_sel1 && req1_lock_i)) begin
                        w_rr_ptr_next = ~w_sel1;
                    end
                end else if (w_timeout) begin
                    w_state_next  = ST_GAP;
                    w_grant_next  = GRANT_NONE;
                    w_lock_next   = 1'b0;
                    w_rr_ptr_next = ~w_sel1;
                end
            end
            ST_GAP: begin
                w_lock_next = 1'b0;
                if (r_lock && req1_valid_i) begin
                    w_state_next = ST_BUSY;
                    w_grant_next = GRANT_LOADER;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_grant_next = GRANT_NONE;
                w_lock_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state  <= ST_IDLE;
            r_grant  <= GRANT_NONE;
            r_rr_ptr <= 1'b0;
            r_lock   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_grant  <= w_grant_next;
            r_rr_ptr <= w_rr_ptr_next;
            r_lock   <= w_lock_next;
        end
    end

    assign mem_valid_o  = w_busy & w_req_valid;
    assign mem_addr_o   = w_busy ? (w_sel1 ? req1_addr_i : req0_addr_i) : '0;
    assign mem_wdata_o  = w_busy ? (w_sel1 ? req1_wdata_i : req0_wdata_i) : '0;
    assign mem_wstrb_o  = w_busy ? (w_sel1 ? req1_wstrb_i : req0_wstrb_i) : 4'h0;
    assign grant_o      = r_grant;

    assign req0_ready_o = w_finish & ~w_sel1;
    assign req1_ready_o = w_finish & w_sel1;
    assign req0_rdata_o = req0_ready_o ? w_rdata : '0;
    assign req1_rdata_o = req1_ready_o ? w_rdata : '0;

endmodule
